ct_tag_fifo: RTL



---
 rtl/ct_tag_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/ct_tag_fifo.sv
// Tagged input FIFO for the constant-time masking stage: each data word travels
// with its ct tag, and the head is forced to zero whenever no entry is valid.
module ct_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_ct,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_ct,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [PW-1:0]   rp_q, rp_d;
    logic [PW-1:0]   wp_q, wp_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_s, pop_s;
    logic [WIDTH:0]  head_s;

    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != {CW{1'b0}});
    assign count     = count_q;
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Pointer and occupancy next state; flush discards everything including this cycle's push.
    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        if (flush) begin
            rp_d    = {PW{1'b0}};
            wp_d    = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wp_d = wp_q + PTR_ONE;
            end else begin
                wp_d = wp_q;
            end
            if (pop_s) begin
                rp_d = rp_q + PTR_ONE;
            end else begin
                rp_d = rp_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rp_q    <= {PW{1'b0}};
            wp_q    <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents survive reset and flush since stale entries are never shown.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_s) begin
            mem_q[wp_q] <= {in_ct, in_data};
        end
    end

    assign head_s   = mem_q[rp_q];
    assign out_data = out_valid ? head_s[WIDTH-1:0] : {WIDTH{1'b0}};
    assign out_ct   = out_valid ? head_s[WIDTH] : 1'b0;

endmodule
